// File: rtl/sram_lsu_master.sv
// Load/store initiator for a single-port SRAM: one access per request, lane-aligned stores, extended loads.
// Optional statistics counters are enabled by defining SRAM_LSU_STATS_EN.
module sram_lsu_master #(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT,
  output logic [15:0]       STAT_RD,
  output logic [15:0]       STAT_WR,
  output logic [15:0]       STAT_ERR
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_csn_q, mem_csn_d;
  logic              mem_wen_q, mem_wen_d;
  logic [BW-1:0]     mem_be_q, mem_be_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_di_q, mem_di_d;

  logic              req_err_c;
  logic [DW-1:0]     ld_shift_c;
  logic [DW-1:0]     ld_data_c;

  // Request rejection: illegal size, misalignment, or beyond the SRAM window
  always_comb begin
    req_err_c = (REQ_SIZE == 2'b11)
              | ((REQ_SIZE == 2'b01) & REQ_ADDR[0])
              | ((REQ_SIZE == 2'b10) & (|REQ_ADDR[1:0]))
              | ((REQ_ADDR >> (AWIDTH + 2)) != 32'd0);
  end

  // Lane extraction and extension of the SRAM read word
  always_comb begin
    ld_shift_c = MEM_DOUT >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_data_c = uns_q ? {24'd0, ld_shift_c[7:0]}
                                 : {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      2'b01:   ld_data_c = uns_q ? {16'd0, ld_shift_c[15:0]}
                                 : {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_csn_d   = 1'b1;
    mem_wen_d   = 1'b1;
    mem_be_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_di_d    = mem_di_q;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          we_d        = REQ_WE;
          size_d      = REQ_SIZE;
          uns_d       = REQ_UNSIGNED;
          off_d       = REQ_ADDR[1:0];
          req_ready_d = 1'b0;
          if (req_err_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = S_ACCESS;
            mem_csn_d  = 1'b0;
            mem_wen_d  = ~REQ_WE;
            mem_addr_d = REQ_ADDR[AWIDTH+1:2];
            if (REQ_WE) begin
              case (REQ_SIZE)
                2'b00: begin
                  mem_be_d = BW'(4'b0001 << REQ_ADDR[1:0]);
                  mem_di_d = {4{REQ_WDATA[7:0]}};
                end
                2'b01: begin
                  mem_be_d = BW'(4'b0011 << REQ_ADDR[1:0]);
                  mem_di_d = {2{REQ_WDATA[15:0]}};
                end
                default: begin
                  mem_be_d = 4'b1111;
                  mem_di_d = REQ_WDATA;
                end
              endcase
            end
          end
        end
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? '0 : ld_data_c;
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_csn_q   <= 1'b1;
      mem_wen_q   <= 1'b1;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_di_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_csn_q   <= mem_csn_d;
      mem_wen_q   <= mem_wen_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_di_q    <= mem_di_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign MEM_CSN   = mem_csn_q;
  assign MEM_WEN   = mem_wen_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DI    = mem_di_q;

`ifdef SRAM_LSU_STATS_EN
  logic          rsp_hs_c;
  logic [SW-1:0] stat_rd_q, stat_rd_d;
  logic [SW-1:0] stat_wr_q, stat_wr_d;
  logic [SW-1:0] stat_err_q, stat_err_d;

  // Saturating counters, bumped on each response handshake
  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    rsp_hs_c   = (state_q == S_RESP) & RSP_READY;
    if (rsp_hs_c) begin
      if (rsp_err_q) begin
        if (stat_err_q != '1) stat_err_d = stat_err_q + SW'(1);
      end else if (we_q) begin
        if (stat_wr_q != '1) stat_wr_d = stat_wr_q + SW'(1);
      end else begin
        if (stat_rd_q != '1) stat_rd_d = stat_rd_q + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign STAT_RD  = stat_rd_q;
  assign STAT_WR  = stat_wr_q;
  assign STAT_ERR = stat_err_q;
`else
  assign STAT_RD  = '0;
  assign STAT_WR  = '0;
  assign STAT_ERR = '0;
`endif

endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed bench for sram_lsu_master with a behavioural single-port SRAM model.
module tb_sram_lsu_master;

  logic        CLK;
  logic        RSTn;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        MEM_CSN;
  logic        MEM_WEN;
  logic [3:0]  MEM_BE;
  logic [11:0] MEM_ADDR;
  logic [31:0] MEM_DI;
  logic [31:0] MEM_DOUT;
  logic [15:0] STAT_RD;
  logic [15:0] STAT_WR;
  logic [15:0] STAT_ERR;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:4095];
  logic        mem_clr;

  sram_lsu_master #(.AWIDTH(12)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .MEM_CSN(MEM_CSN),
    .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI),
    .MEM_DOUT(MEM_DOUT), .STAT_RD(STAT_RD), .STAT_WR(STAT_WR), .STAT_ERR(STAT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: byte-masked write on falling edge, asynchronous read
  always @(negedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      mem[5] = 32'h1234_5678;
    end else if (!MEM_CSN && !MEM_WEN) begin
      for (int b = 0; b < 4; b++)
        if (MEM_BE[b]) mem[MEM_ADDR][b*8 +: 8] = MEM_DI[b*8 +: 8];
    end
  end
  assign MEM_DOUT = mem[MEM_ADDR];

  // One request with RSP_READY high; captures the ACCESS-cycle SRAM signals
  task automatic xact(input logic we, input logic [1:0] sz, input logic un,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output int lo, output logic [3:0] be, output logic [31:0] di,
                      output logic [11:0] ma, output logic wn);
    int n;
    logic got;
    rd = '0; er = 1'b0; lat = 0; lo = 0; be = '0; di = '0; ma = '0; wn = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 20) begin @(negedge CLK); n++; end
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = un;
    REQ_ADDR = ad; REQ_WDATA = wd;
    @(posedge CLK); #1 REQ_VALID = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge CLK); n++;
      if (!MEM_CSN) begin lo++; be = MEM_BE; di = MEM_DI; ma = MEM_ADDR; wn = MEM_WEN; end
      if (RSP_VALID) begin got = 1'b1; rd = RSP_RDATA; er = RSP_ERR; lat = n; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL xact_timeout addr=%h no RSP_VALID within 20 cycles", ad);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    vectors++; if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b exp 1", REQ_READY); end
    vectors++; if (RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", RSP_VALID); end
    vectors++; if (RSP_RDATA !== 32'd0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", RSP_RDATA); end
    vectors++; if (RSP_ERR !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", RSP_ERR); end
    vectors++; if ({MEM_CSN, MEM_WEN} !== 2'b11) begin miscompares++; $display("FAIL rst_csn_wen got %b exp 11", {MEM_CSN, MEM_WEN}); end
    vectors++; if (MEM_BE !== 4'd0) begin miscompares++; $display("FAIL rst_be got %b exp 0000", MEM_BE); end
    vectors++; if (MEM_ADDR !== 12'd0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", MEM_ADDR); end
    vectors++; if (MEM_DI !== 32'd0) begin miscompares++; $display("FAIL rst_di got %h exp 0", MEM_DI); end
    vectors++; if ({STAT_RD, STAT_WR, STAT_ERR} !== 48'd0) begin miscompares++; $display("FAIL rst_stats got %h exp 0", {STAT_RD, STAT_WR, STAT_ERR}); end
  endtask

  task automatic test_word();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (ma !== 12'd4) begin miscompares++; $display("FAIL sw_addr got %h exp 4", ma); end
    vectors++; if (be !== 4'b1111) begin miscompares++; $display("FAIL sw_be got %b exp 1111", be); end
    vectors++; if (di !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_di got %h exp deadbeef", di); end
    vectors++; if (wn !== 1'b0) begin miscompares++; $display("FAIL sw_wen got %b exp 0", wn); end
    vectors++; if (lo !== 1) begin miscompares++; $display("FAIL sw_csn_cycles got %0d exp 1", lo); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d exp 2", lat); end
    vectors++; if ({er, rd} !== 33'd0) begin miscompares++; $display("FAIL sw_rsp got err=%b rdata=%h exp 0/0", er, rd); end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL lw_err got %b exp 0", er); end
    vectors++; if ({wn, be} !== 5'b1_0000) begin miscompares++; $display("FAIL lw_wen_be got %b exp 10000", {wn, be}); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (be !== 4'b1000) begin miscompares++; $display("FAIL sb_be got %b exp 1000", be); end
    vectors++; if (di !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL sb_di got %h exp a5a5a5a5", di); end
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'hFFFF_FFA5) begin miscompares++; $display("FAIL lb_signed got %h exp ffffffa5", rd); end
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'h0000_00A5) begin miscompares++; $display("FAIL lbu got %h exp 000000a5", rd); end
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'hFFFF_FFBE) begin miscompares++; $display("FAIL lb_lane1 got %h exp ffffffbe", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    xact(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_8001, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got %b exp 1100", be); end
    vectors++; if (di !== 32'h8001_8001) begin miscompares++; $display("FAIL sh_di got %h exp 80018001", di); end
    xact(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_signed got %h exp ffff8001", rd); end
    xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'h8001_5678) begin miscompares++; $display("FAIL lw_merge got %h exp 80015678", rd); end
    xact(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'h0000_5678) begin miscompares++; $display("FAIL lhu_low got %h exp 00005678", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    logic [1:0]  sz_t [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ad_t [4] = '{32'h11, 32'h12, 32'h10, 32'h4000};
    for (int k = 0; k < 4; k++) begin
      xact(1'b0, sz_t[k], 1'b0, ad_t[k], 32'hFFFF_FFFF, rd, er, lat, lo, be, di, ma, wn);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL err%0d_flag got %b exp 1", k, er); end
      vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL err%0d_rdata got %h exp 0", k, rd); end
      vectors++; if (lo !== 0) begin miscompares++; $display("FAIL err%0d_csn_cycles got %0d exp 0", k, lo); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL err%0d_latency got %0d exp 1", k, lat); end
    end
    xact(1'b1, 2'b10, 1'b0, 32'h4010, 32'h0BAD_0BAD, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if ({er, lo} !== {1'b1, 32'd0}) begin miscompares++; $display("FAIL err_store got err=%b csn_cycles=%0d exp 1/0", er, lo); end
    vectors++; if (mem[4] !== 32'hA5AD_BEEF) begin miscompares++; $display("FAIL err_store_mem got %h exp a5adbeef", mem[4]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    RSP_READY = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h10;
    @(posedge CLK); #1;
    REQ_WE = 1'b1; REQ_WDATA = 32'h0; REQ_ADDR = 32'h10;
    @(negedge CLK);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      vectors++; if ({RSP_VALID, REQ_READY} !== 2'b10) begin miscompares++; $display("FAIL bp%0d_valid_ready got %b exp 10", c, {RSP_VALID, REQ_READY}); end
      vectors++; if (RSP_RDATA !== 32'hA5AD_BEEF) begin miscompares++; $display("FAIL bp%0d_rdata got %h exp a5adbeef", c, RSP_RDATA); end
      vectors++; if (MEM_CSN !== 1'b1) begin miscompares++; $display("FAIL bp%0d_csn got %b exp 1", c, MEM_CSN); end
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    vectors++; if ({RSP_VALID, REQ_READY} !== 2'b01) begin miscompares++; $display("FAIL bp_release got %b exp 01", {RSP_VALID, REQ_READY}); end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'hA5AD_BEEF) begin miscompares++; $display("FAIL bp_ignored_store got %h exp a5adbeef", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, rd, er, lat, lo, be, di, ma, wn);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_ADDR = 32'h20; REQ_WDATA = 32'hCAFE_F00D;
    @(posedge CLK); #1 REQ_VALID = 1'b0;
    vectors++; if (MEM_CSN !== 1'b0) begin miscompares++; $display("FAIL abort_in_access got csn=%b exp 0", MEM_CSN); end
    RSTn = 1'b0; #1;
    vectors++; if ({MEM_CSN, MEM_WEN} !== 2'b11) begin miscompares++; $display("FAIL abort_csn_wen got %b exp 11", {MEM_CSN, MEM_WEN}); end
    vectors++; if ({REQ_READY, RSP_VALID} !== 2'b10) begin miscompares++; $display("FAIL abort_idle got %b exp 10", {REQ_READY, RSP_VALID}); end
    @(negedge CLK); #1 RSTn = 1'b1;
    vectors++; if (mem[8] !== 32'h1122_3344) begin miscompares++; $display("FAIL abort_mem got %h exp 11223344", mem[8]); end
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    vectors++; if (rd !== 32'h1122_3344) begin miscompares++; $display("FAIL abort_load got %h exp 11223344", rd); end
  endtask

  task automatic test_stats();
    logic [31:0] rd, di; logic er, wn; int lat, lo; logic [3:0] be; logic [11:0] ma;
    logic [15:0] e_rd, e_wr, e_err;
    @(negedge CLK); RSTn = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    xact(1'b1, 2'b00, 1'b0, 32'h30, 32'h77, rd, er, lat, lo, be, di, ma, wn);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    xact(1'b1, 2'b10, 1'b0, 32'h34, 32'h55, rd, er, lat, lo, be, di, ma, wn);
    xact(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd, er, lat, lo, be, di, ma, wn);
    @(negedge CLK);
`ifdef SRAM_LSU_STATS_EN
    e_rd = 16'd3; e_wr = 16'd2; e_err = 16'd1;
`else
    e_rd = 16'd0; e_wr = 16'd0; e_err = 16'd0;
`endif
    vectors++; if (STAT_RD !== e_rd) begin miscompares++; $display("FAIL stat_rd got %0d exp %0d", STAT_RD, e_rd); end
    vectors++; if (STAT_WR !== e_wr) begin miscompares++; $display("FAIL stat_wr got %0d exp %0d", STAT_WR, e_wr); end
    vectors++; if (STAT_ERR !== e_err) begin miscompares++; $display("FAIL stat_err got %0d exp %0d", STAT_ERR, e_err); end
  endtask

  initial begin
    RSTn = 1'b0; mem_clr = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    mem_clr = 1'b0;
    test_reset();
    RSTn = 1'b1;
    @(negedge CLK);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
